// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: single-clock FIFO around a dual-port register file with registered read data and status flags
// Ports: clk, rst_n (async active-low); winc/wdata write side with wfull, walmost_full;
// rinc read side with rdata, rvalid, rempty, ralmost_empty; count = occupancy 0..DEPTH.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_mem #(
  parameter int DATASIZE   = 8,
  parameter int ADDRSIZE   = 4,
  parameter int AFULL_LVL  = (1 << ADDRSIZE) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  output logic                wfull,
  output logic                walmost_full,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                overflow,
  output logic                underflow
`endif
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AF = AFULL_LVL[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] AE = AEMPTY_LVL[ADDRSIZE:0];
  logic [DATASIZE-1:0] mem [DEPTH];
  logic [ADDRSIZE:0] wptr, rptr;
  logic rd_ok, wr_ok;
  assign count         = wptr - rptr;
  assign rempty        = wptr == rptr;
  assign wfull         = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) && (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
  assign walmost_full  = count >= AF;
  assign ralmost_empty = count <= AE;
  assign rd_ok         = rinc && !rempty;
  // a pop on the same edge frees the slot, so a full FIFO may still accept a write
  assign wr_ok         = winc && (!wfull || rd_ok);
  always_ff @(posedge clk)
    if (wr_ok) mem[wptr[ADDRSIZE-1:0]] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      wptr   <= wr_ok ? wptr + 1'b1 : wptr;
      rptr   <= rd_ok ? rptr + 1'b1 : rptr;
      rdata  <= rd_ok ? mem[rptr[ADDRSIZE-1:0]] : rdata;
      rvalid <= rd_ok;
    end
`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow || (winc && wfull && !rd_ok);
      underflow <= underflow || (rinc && rempty);
    end
`endif
endmodule

// File: doc/sync_fifo_mem.md
# sync_fifo_mem

Single-clock, parametrised FIFO that wraps a dual-port register-file memory with its own read/write pointers, status flags and occupancy count. It is the successor to the bare dual-clock memory array: it adds registered read data, programmable almost-full/almost-empty thresholds, a live fill count and full/empty protection internally. It sits between producer and consumer logic inside one clock domain, replacing hand-built pointer logic around the raw memory.

## Interface
- DATASIZE, 8, memory word width in bits
- ADDRSIZE, 4, address bits; DEPTH = 1<<ADDRSIZE entries
- AFULL_LVL, DEPTH-2, walmost_full asserts when count >= AFULL_LVL (legal range 1..DEPTH)
- AEMPTY_LVL, 2, ralmost_empty asserts when count <= AEMPTY_LVL (legal range 0..DEPTH-1)

- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- winc  input  1  write request
- wdata  input  DATASIZE  write data
- wfull  output  1  FIFO holds DEPTH entries
- walmost_full  output  1  count >= AFULL_LVL
- rinc  input  1  read request
- rdata  output  DATASIZE  registered read data
- rvalid  output  1  rdata carries the word popped on the previous edge
- rempty  output  1  FIFO holds 0 entries
- ralmost_empty  output  1  count <= AEMPTY_LVL
- count  output  ADDRSIZE+1  current occupancy, 0..DEPTH
- overflow, underflow  output  1 each  sticky error flags (present only with FIFO_ERR_FLAGS_EN)

## Operation
- Pointers wptr, rptr are ADDRSIZE+1 bits; low ADDRSIZE bits address memory, MSB is wrap bit.
- count = wptr - rptr (modulo 2^(ADDRSIZE+1)); rempty = (wptr == rptr); wfull = (MSBs differ, low bits equal).
- Read accepted (rd_ok) = rinc && !rempty. On rd_ok: rdata <= mem[rptr low bits], rptr increments, rvalid <= 1; otherwise rvalid <= 0 and rdata holds its value.
- Write accepted (wr_ok) = winc && (!wfull || rd_ok). On wr_ok: mem[wptr low bits] <= wdata, wptr increments.
- Simultaneous rd_ok and wr_ok: both pointers advance, count unchanged. When full, read slot data is captured before overwrite (same-edge nonblocking semantics), so rdata returns the old word.
- Write on empty with rinc in same cycle: write accepted, read rejected (no bypass); word readable next cycle.
- Rejected requests (winc on full without read, rinc on empty) leave all state unchanged.
- Pointer wrap: after DEPTH writes wptr low bits return to 0, MSB toggles; no special handling needed.
- Memory array is not reset; contents undefined until written.

## Timing
- Reset (asynchronous, immediate on rst_n low): wptr = rptr = 0, count = 0, rempty = 1, wfull = 0, ralmost_empty = 1, walmost_full = 0, rdata = 0, rvalid = 0, overflow = underflow = 0.
- Reset mid-operation discards all stored words; first edge after rst_n rises behaves as empty FIFO.
- Flags and count are combinational from registered pointers: they reflect the state after the most recent edge, zero extra latency.
- Read latency: rinc sampled at edge N -> rdata/rvalid valid after edge N, i.e. during cycle N+1.
- Write-to-read latency: word written at edge N can be popped by rinc at edge N+1, appearing on rdata after edge N+1.
- Sustained throughput: one write and one read per cycle.

## Configuration
- FIFO_ERR_FLAGS_EN defined: overflow sets on winc && wfull && !rd_ok; underflow sets on rinc && rempty; both stay set until rst_n asserted.
- FIFO_ERR_FLAGS_EN undefined: overflow/underflow ports and their logic are absent; rejected requests are silently ignored.

## Test plan
- Reset, then 16 writes 0x00..0x0F (default params) -> wfull=1 after 16th edge, count=16, walmost_full=1 from count 14; 17th winc ignored, overflow=1 if enabled.
- 16 reads from full -> rdata sequence 0x00..0x0F each with rvalid=1 one cycle after rinc; rempty=1, count=0 after last; further rinc gives rvalid=0, underflow=1 if enabled.
- Hold count=8, assert winc and rinc together for 40 cycles -> count stays 8, data ordered, pointers wrap twice with no loss.
- Full FIFO, winc+rinc same cycle with wdata=0xAA -> rdata=oldest word, count stays 16, 0xAA emerges 16th later.
- Empty FIFO, winc+rinc same cycle -> rvalid=0, count=1; next-cycle rinc returns written word.
- Assert rst_n low mid-stream with count=5 -> all outputs at reset values immediately, before next clk edge.
